// File: rtl/module_mem_arbiter_multicycle_if.sv
// rtl/module_mem_arbiter_multicycle_if.sv - requester ports and memory-macro side of the arbiter
interface module_mem_arbiter_multicycle_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
);
    localparam int MA_W = $clog2(MEM_WORDS);

    logic              req0_i;
    logic              req1_i;
    logic              we0_i;
    logic              we1_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic              ack0_o;
    logic              ack1_o;
    logic              err0_o;
    logic              err1_o;
    logic [DATA_W-1:0] rdata_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [MA_W-1:0]   mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              busy_o;

    modport slave (
        input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
        output ack0_o, ack1_o, err0_o, err1_o, rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );

    modport master (
        output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
        input  ack0_o, ack1_o, err0_o, err1_o, rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );
endinterface

// File: rtl/module_mem_arbiter_multicycle.sv
// rtl/module_mem_arbiter_multicycle.sv - round-robin two-master arbiter for a fixed-latency single-port memory
module module_mem_arbiter_multicycle #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int MEM_LAT   = 1
) (
    input logic clk_i,
    input logic rst_i,
    module_mem_arbiter_multicycle_if.slave bus
);
    localparam int MA_W  = $clog2(MEM_WORDS);
    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LOAD  = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]        state;
    logic              gnt_id;
    logic              last_served;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] rdata_q;

    logic illegal;
    logic grant1;
    logic issue_ok;
    logic ack_read;

    assign illegal  = (lat_addr[1:0] != 2'b00) || (lat_addr >= ADDR_LIMIT);
    assign issue_ok = (state == S_ISSUE) && !illegal;
    assign ack_read = (state == S_ACK) && !lat_we && !illegal;

    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    assign grant1 = bus.req1_i && (!bus.req0_i || !last_served);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            gnt_id      <= 1'b0;
            last_served <= 1'b1;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            wait_cnt    <= '0;
            rdata_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req0_i || bus.req1_i) begin
                        gnt_id      <= grant1;
                        last_served <= grant1;
                        lat_we      <= grant1 ? bus.we1_i    : bus.we0_i;
                        lat_addr    <= grant1 ? bus.addr1_i  : bus.addr0_i;
                        lat_wdata   <= grant1 ? bus.wdata1_i : bus.wdata0_i;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (illegal || (MEM_LAT == 1)) begin
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    if (ack_read) begin
                        rdata_q <= bus.mem_rdata_i;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign bus.mem_en_o    = issue_ok;
    assign bus.mem_we_o    = issue_ok && lat_we;
    assign bus.mem_addr_o  = lat_addr[MA_W+1:2];
    assign bus.mem_wdata_o = lat_wdata;

    assign bus.ack0_o = (state == S_ACK) && !gnt_id;
    assign bus.ack1_o = (state == S_ACK) && gnt_id;
    assign bus.err0_o = (state == S_ACK) && !gnt_id && illegal;
    assign bus.err1_o = (state == S_ACK) && gnt_id && illegal;

    assign bus.rdata_o = ack_read ? bus.mem_rdata_i : rdata_q;
    assign bus.busy_o  = (state != S_IDLE);
endmodule

// File: tb/tb_module_mem_arbiter_multicycle.sv
// tb/tb_module_mem_arbiter_multicycle.sv - self-checking bench for the two-master memory arbiter
module tb_module_mem_arbiter_multicycle;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 1024;
    localparam int MA_W      = $clog2(MEM_WORDS);
    localparam int LAT_A     = 1;
    localparam int LAT_B     = 3;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    module_mem_arbiter_multicycle_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) ifa ();
    module_mem_arbiter_multicycle_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) ifb ();

    module_mem_arbiter_multicycle #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .MEM_LAT(LAT_A))
        dut_a (.clk_i(clk), .rst_i(rst_a_n), .bus(ifa));
    module_mem_arbiter_multicycle #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .MEM_LAT(LAT_B))
        dut_b (.clk_i(clk), .rst_i(rst_b_n), .bus(ifb));

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
    endfunction

    // Memory macros: read data appears exactly LAT cycles after the strobe, poison otherwise.
    logic [31:0] mem_a [MEM_WORDS];
    logic [31:0] mem_b [MEM_WORDS];
    logic [31:0] rd_a = POISON;
    logic [31:0] pipe_b [LAT_B];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_a[i] = init_word(i);
            mem_b[i] = init_word(i);
        end
    end

    always @(posedge clk) begin
        if (ifa.mem_en_o && ifa.mem_we_o) mem_a[ifa.mem_addr_o] <= ifa.mem_wdata_o;
        rd_a <= (ifa.mem_en_o && !ifa.mem_we_o) ? mem_a[ifa.mem_addr_o] : POISON;
    end
    assign ifa.mem_rdata_i = rd_a;

    always @(posedge clk) begin
        if (ifb.mem_en_o && ifb.mem_we_o) mem_b[ifb.mem_addr_o] <= ifb.mem_wdata_o;
        pipe_b[0] <= (ifb.mem_en_o && !ifb.mem_we_o) ? mem_b[ifb.mem_addr_o] : POISON;
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign ifb.mem_rdata_i = pipe_b[LAT_B-1];

    int              en_cnt_a = 0;
    logic [MA_W-1:0] en_addr_a = '0;
    logic            en_we_a = 1'b0;
    logic [31:0]     en_wdata_a = '0;
    always @(posedge clk) begin
        if (ifa.mem_en_o) begin
            en_cnt_a   <= en_cnt_a + 1;
            en_addr_a  <= ifa.mem_addr_o;
            en_we_a    <= ifa.mem_we_o;
            en_wdata_a <= ifa.mem_wdata_o;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] sh_a [MEM_WORDS];
    bit          model_last;
    logic [31:0] model_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(0, 15));
        if (r == 0) return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        if (r == 1) return 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 15)) * 4;
        if (r == 2) return 32'(MEM_WORDS * 4 - 4);
        return 32'($urandom_range(0, 15)) * 4;
    endfunction

    // One arbitration episode on the MEM_LAT=1 instance, starting from IDLE.
    task automatic round_a(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] a [2];
        logic [31:0] d [2];
        bit          w [2];
        int          order [$];
        int          en_before;
        int          exp_en;
        int          n;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; w[0] = w0; w[1] = w1;
        ifa.req0_i = r0; ifa.we0_i = w0; ifa.addr0_i = a0; ifa.wdata0_i = d0;
        ifa.req1_i = r1; ifa.we1_i = w1; ifa.addr1_i = a1; ifa.wdata1_i = d1;
        if (r0 && r1) begin
            order.push_back(model_last ? 0 : 1);
            order.push_back(model_last ? 1 : 0);
        end else begin
            order.push_back(r0 ? 0 : 1);
        end
        en_before = en_cnt_a;
        exp_en    = 0;
        for (int k = 0; k < order.size(); k++) begin
            int p = order[k];
            bit legal = (a[p][1:0] == 2'b00) && (a[p] < 32'(MEM_WORDS * 4));
            int exp_lat = (legal ? LAT_A + 1 : 2) + ((k > 0) ? 1 : 0);
            n = 0;
            while (n < 50) begin
                tick();
                n++;
                if (ifa.ack0_o || ifa.ack1_o) break;
            end
            check("rr_latency", 32'(n), 32'(exp_lat));
            check("rr_ack0", 32'(ifa.ack0_o), 32'(p == 0));
            check("rr_ack1", 32'(ifa.ack1_o), 32'(p == 1));
            check("rr_err", 32'((p == 1) ? ifa.err1_o : ifa.err0_o), 32'(!legal));
            check("rr_err_other", 32'((p == 1) ? ifa.err0_o : ifa.err1_o), 32'd0);
            if (legal) begin
                exp_en++;
                if (w[p]) sh_a[a[p][MA_W+1:2]] = d[p];
                else      model_rdata = sh_a[a[p][MA_W+1:2]];
            end
            check("rr_rdata", ifa.rdata_o, model_rdata);
            model_last = (p == 1);
            if (p == 0) ifa.req0_i = 1'b0;
            else        ifa.req1_i = 1'b0;
        end
        tick();
        check("rr_mem_en_count", 32'(en_cnt_a - en_before), 32'(exp_en));
        check("rr_busy_idle", 32'(ifa.busy_o), 32'd0);
    endtask

    task automatic wait_ack_b(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(ifb.ack0_o || ifb.ack1_o) && n < 40);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;
        logic [31:0] d6;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        ifa.req0_i = 0; ifa.req1_i = 0; ifa.we0_i = 0; ifa.we1_i = 0;
        ifa.addr0_i = '0; ifa.addr1_i = '0; ifa.wdata0_i = '0; ifa.wdata1_i = '0;
        ifb.req0_i = 0; ifb.req1_i = 0; ifb.we0_i = 0; ifb.we1_i = 0;
        ifb.addr0_i = '0; ifb.addr1_i = '0; ifb.wdata0_i = '0; ifb.wdata1_i = '0;
        for (int i = 0; i < MEM_WORDS; i++) sh_a[i] = init_word(i);
        model_last  = 1'b1;
        model_rdata = '0;
        tick(); tick();

        check("reset_ack0", 32'(ifa.ack0_o), 32'd0);
        check("reset_ack1", 32'(ifa.ack1_o), 32'd0);
        check("reset_err0", 32'(ifa.err0_o), 32'd0);
        check("reset_err1", 32'(ifa.err1_o), 32'd0);
        check("reset_rdata", ifa.rdata_o, 32'd0);
        check("reset_mem_en", 32'(ifa.mem_en_o), 32'd0);
        check("reset_mem_we", 32'(ifa.mem_we_o), 32'd0);
        check("reset_mem_addr", 32'(ifa.mem_addr_o), 32'd0);
        check("reset_mem_wdata", ifa.mem_wdata_o, 32'd0);
        check("reset_busy", 32'(ifa.busy_o), 32'd0);

        // Both masters requesting from reset and holding: strict alternation starting at port 0.
        ifa.req0_i = 1; ifa.addr0_i = 32'h10;
        ifa.req1_i = 1; ifa.addr1_i = 32'h20;
        rst_a_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (n < 50) begin
                tick();
                n++;
                if (ifa.ack0_o || ifa.ack1_o) break;
            end
            check("held_spacing", 32'(n), 32'((k == 0) ? LAT_A + 1 : LAT_A + 2));
            check("held_ack0", 32'(ifa.ack0_o), 32'(k % 2 == 0));
            check("held_ack1", 32'(ifa.ack1_o), 32'(k % 2 == 1));
            check("held_rdata", ifa.rdata_o, (k % 2 == 0) ? sh_a[4] : sh_a[8]);
        end
        ifa.req0_i = 0; ifa.req1_i = 0;
        model_last  = 1'b1;
        model_rdata = sh_a[8];
        tick();

        // Single read, cycle by cycle.
        ifa.req0_i = 1; ifa.we0_i = 0; ifa.addr0_i = 32'h10;
        tick();
        check("t1_mem_en", 32'(ifa.mem_en_o), 32'd1);
        check("t1_mem_we", 32'(ifa.mem_we_o), 32'd0);
        check("t1_mem_addr", 32'(ifa.mem_addr_o), 32'd4);
        check("t1_no_early_ack", 32'(ifa.ack0_o), 32'd0);
        check("t1_busy", 32'(ifa.busy_o), 32'd1);
        tick();
        check("t1_ack0", 32'(ifa.ack0_o), 32'd1);
        check("t1_err0", 32'(ifa.err0_o), 32'd0);
        check("t1_rdata", ifa.rdata_o, 32'hDEAD_BEEF);
        ifa.req0_i = 0;
        model_last  = 1'b0;
        model_rdata = 32'hDEAD_BEEF;
        tick();
        check("t1_rdata_held", ifa.rdata_o, 32'hDEAD_BEEF);

        round_a(0, 1, 0, 1, 32'h0, 32'h08, 32'h0, 32'h1234_5678);
        check("t2_mem_we", 32'(en_we_a), 32'd1);
        check("t2_mem_addr", 32'(en_addr_a), 32'd2);
        check("t2_mem_wdata", en_wdata_a, 32'h1234_5678);

        round_a(1, 0, 0, 0, 32'h3, 32'h0, 32'h0, 32'h0);
        round_a(1, 0, 0, 0, 32'h1000, 32'h0, 32'h0, 32'h0);
        round_a(1, 0, 0, 0, 32'hFFC, 32'h0, 32'h0, 32'h0);
        round_a(1, 1, 1, 0, 32'h08, 32'h08, 32'hCAFE_F00D, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            round_a(sel != 1, sel != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rand_addr(), rand_addr(), $urandom, $urandom);
        end

        // MEM_LAT=3 instance: async reset during ISSUE and WAIT.
        rst_b_n = 1'b1;
        tick();
        ifb.req0_i = 1; ifb.we0_i = 1; ifb.addr0_i = 32'h44; ifb.wdata0_i = 32'h7777_0000;
        tick();
        check("t5_issue_en", 32'(ifb.mem_en_o), 32'd1);
        check("t5_issue_we", 32'(ifb.mem_we_o), 32'd1);
        rst_b_n = 1'b0;
        #1;
        check("t5_async_en", 32'(ifb.mem_en_o), 32'd0);
        check("t5_async_we", 32'(ifb.mem_we_o), 32'd0);
        ifb.req0_i = 0;
        tick();
        rst_b_n = 1'b1;
        tick();
        ifb.req0_i = 1; ifb.we0_i = 0; ifb.addr0_i = 32'h40;
        tick();
        tick();
        check("t5_wait_busy", 32'(ifb.busy_o), 32'd1);
        rst_b_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(ifb.busy_o), 32'd0);
        check("t5_rst_mem_addr", 32'(ifb.mem_addr_o), 32'd0);
        check("t5_rst_rdata", ifb.rdata_o, 32'd0);
        ifb.req0_i = 0;
        tick();
        rst_b_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ifb.ack0_o || ifb.ack1_o) acks++;
        end
        check("t5_no_ack_after_reset", 32'(acks), 32'd0);

        ifb.req0_i = 1; ifb.we0_i = 0; ifb.addr0_i = 32'h40;
        wait_ack_b(n);
        check("t5_next_latency", 32'(n), 32'(LAT_B + 1));
        check("t5_next_ack0", 32'(ifb.ack0_o), 32'd1);
        check("t5_next_rdata", ifb.rdata_o, init_word(16));
        ifb.req0_i = 0;
        tick();

        // Port 1 arrives while port 0 is in WAIT; served right after port 0.
        d6 = $urandom;
        ifb.req0_i = 1; ifb.we0_i = 0; ifb.addr0_i = 32'h48;
        tick();
        tick();
        ifb.req1_i = 1; ifb.we1_i = 1; ifb.addr1_i = 32'h4C; ifb.wdata1_i = d6;
        wait_ack_b(n);
        check("t6_ack0_latency", 32'(n + 2), 32'(LAT_B + 1));
        check("t6_ack0", 32'(ifb.ack0_o), 32'd1);
        check("t6_rdata0", ifb.rdata_o, init_word(18));
        ifb.req0_i = 0;
        wait_ack_b(n);
        check("t6_ack1_latency", 32'(n), 32'(LAT_B + 2));
        check("t6_ack1", 32'(ifb.ack1_o), 32'd1);
        check("t6_err1", 32'(ifb.err1_o), 32'd0);
        check("t6_rdata_kept", ifb.rdata_o, init_word(18));
        ifb.req1_i = 0;
        tick();
        ifb.req0_i = 1; ifb.we0_i = 0; ifb.addr0_i = 32'h4C;
        wait_ack_b(n);
        check("t6_readback_latency", 32'(n), 32'(LAT_B + 1));
        check("t6_readback", ifb.rdata_o, d6);
        ifb.req0_i = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
